// File: rtl/clock_seq_pkg.sv
// rtl/clock_seq_pkg.sv - shared types and constants for the clock-source sequencer
package clock_seq_pkg;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        GATE_OFF  = 3'd1,
        SWITCH    = 3'd2,
        SETTLE_ON = 3'd3,
        GATE_ON   = 3'd4
    } seq_state_e;

    typedef struct packed {
        logic sel;
        logic inv;
    } clk_cfg_t;

    localparam logic TEST_SEL = 1'b1;
    localparam logic TEST_INV = 1'b0;

endpackage

// File: rtl/clock_seq_timer.sv
// rtl/clock_seq_timer.sv - saturating settle counter with terminal count at SETTLE_CYC-1
module clock_seq_timer #(
    parameter int SETTLE_CYC = 4,
    parameter int CNT_W      = 4
) (
    input  logic CLK,
    input  logic RST,
    input  logic i_clr,
    input  logic i_en,
    output logic o_tc
);

    localparam logic [CNT_W-1:0] TC_VAL = CNT_W'(SETTLE_CYC - 1);

    logic [CNT_W-1:0] r_cnt;

    // Holding at the terminal value keeps the counter from ever wrapping.
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_cnt <= '0;
        end else if (i_clr) begin
            r_cnt <= '0;
        end else if (i_en && !o_tc) begin
            r_cnt <= r_cnt + CNT_W'(1);
        end
    end

    assign o_tc = (r_cnt == TC_VAL);

endmodule

// File: rtl/clock_source_seq.sv
// rtl/clock_source_seq.sv - glitch-safe sequencer for clock-source mux select and inversion
module clock_source_seq
    import clock_seq_pkg::*;
#(
    parameter int SETTLE_CYC = 4,
    parameter int CNT_W      = 4
) (
    input  logic CLK,
    input  logic RST,
    input  logic req_valid,
    input  logic req_sel,
    input  logic req_inv,
    output logic req_ready,
    input  logic test_mode,
    output logic gate_en,
    output logic mux_sel,
    output logic inv_sel,
    output logic busy,
    output logic done
);

    seq_state_e r_state;
    seq_state_e w_state_nxt;
    clk_cfg_t   r_sw;
    clk_cfg_t   r_tgt;
    clk_cfg_t   r_cur;
    logic       r_gate_en;
    logic       r_busy;
    logic       r_ready;
    logic       r_done;

    clk_cfg_t   w_sw_nxt;
    clk_cfg_t   w_target;
    clk_cfg_t   w_tgt_nxt;
    clk_cfg_t   w_cur_nxt;
    logic       w_accept;
    logic       w_clr;
    logic       w_en;
    logic       w_tc;
    logic       w_noop;
    logic       w_gate_nxt;
    logic       w_busy_nxt;
    logic       w_ready_nxt;
    logic       w_done_nxt;

    clock_seq_timer #(
        .SETTLE_CYC (SETTLE_CYC),
        .CNT_W      (CNT_W)
    ) u_timer (
        .CLK   (CLK),
        .RST   (RST),
        .i_clr (w_clr),
        .i_en  (w_en),
        .o_tc  (w_tc)
    );

    // A request accepted this cycle already counts toward the IDLE target decision.
    assign w_accept = req_valid && r_ready;
    assign w_sw_nxt = w_accept ? clk_cfg_t'{sel: req_sel, inv: req_inv} : r_sw;
    assign w_target = test_mode ? clk_cfg_t'{sel: TEST_SEL, inv: TEST_INV} : w_sw_nxt;

    always_comb begin
        w_state_nxt = r_state;
        w_tgt_nxt   = r_tgt;
        w_cur_nxt   = r_cur;
        w_clr       = 1'b0;
        w_en        = 1'b0;
        w_noop      = 1'b0;
        case (r_state)
            IDLE: begin
                w_clr = 1'b1;
                if (w_target != r_cur) begin
                    w_tgt_nxt   = w_target;
                    w_state_nxt = GATE_OFF;
                end else if (w_accept && !test_mode) begin
                    w_noop = 1'b1;
                end
            end
            GATE_OFF: begin
                w_en = 1'b1;
                if (w_tc) begin
                    // Selects move on entry to SWITCH, with the gate already closed.
                    w_cur_nxt   = r_tgt;
                    w_state_nxt = SWITCH;
                end
            end
            SWITCH: begin
                w_clr       = 1'b1;
                w_state_nxt = SETTLE_ON;
            end
            SETTLE_ON: begin
                w_en = 1'b1;
                if (w_tc) begin
                    w_state_nxt = GATE_ON;
                end
            end
            GATE_ON: begin
                w_state_nxt = IDLE;
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase

        w_gate_nxt  = !(w_state_nxt == GATE_OFF || w_state_nxt == SWITCH ||
                        w_state_nxt == SETTLE_ON);
        w_busy_nxt  = (w_state_nxt != IDLE);
        w_ready_nxt = (w_state_nxt == IDLE);
        w_done_nxt  = (w_state_nxt == GATE_ON) || w_noop;
    end

    // Outputs are registered from the next state so the gate enable never glitches.
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_state   <= IDLE;
            r_sw      <= '0;
            r_tgt     <= '0;
            r_cur     <= '0;
            r_gate_en <= 1'b1;
            r_busy    <= 1'b0;
            r_ready   <= 1'b1;
            r_done    <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_sw      <= w_sw_nxt;
            r_tgt     <= w_tgt_nxt;
            r_cur     <= w_cur_nxt;
            r_gate_en <= w_gate_nxt;
            r_busy    <= w_busy_nxt;
            r_ready   <= w_ready_nxt;
            r_done    <= w_done_nxt;
        end
    end

    assign req_ready = r_ready;
    assign gate_en   = r_gate_en;
    assign mux_sel   = r_cur.sel;
    assign inv_sel   = r_cur.inv;
    assign busy      = r_busy;
    assign done      = r_done;

endmodule
